// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register: modes, directions, FSM states.
// Optional build macro used by the top: PARITY_EN.
package usr_pkg;

  localparam logic [1:0] MODE_SHIFT = 2'b00;
  localparam logic [1:0] MODE_ROT   = 2'b01;
  localparam logic [1:0] MODE_LOAD  = 2'b10;
  localparam logic [1:0] MODE_ARITH = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : usr_pkg

// File: rtl/usr_step.sv
// One shift/rotate/load/arithmetic step of the register; purely combinational.
module usr_step
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] q,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             s_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] next_q,
  output logic             out_bit
);

  logic w_fill_l;
  logic w_fill_r;

  // Bit entering the vacated end, per mode and direction
  always_comb begin
    w_fill_l = s_in;
    w_fill_r = s_in;
    case (mode)
      MODE_ROT: begin
        w_fill_l = q[WIDTH-1];
        w_fill_r = q[0];
      end
      MODE_ARITH: begin
        w_fill_l = 1'b0;
        w_fill_r = q[WIDTH-1];
      end
      default: begin
        w_fill_l = s_in;
        w_fill_r = s_in;
      end
    endcase
  end

  // Assemble the next register value and the bit that leaves it
  always_comb begin
    next_q  = q;
    out_bit = 1'b0;
    case (dir)
      DIR_LEFT: begin
        next_q  = {q[WIDTH-2:0], w_fill_l};
        out_bit = q[WIDTH-1];
      end
      DIR_RIGHT: begin
        next_q  = {w_fill_r, q[WIDTH-1:1]};
        out_bit = q[0];
      end
      default: begin
        next_q  = q;
        out_bit = 1'b0;
      end
    endcase
    if (mode == MODE_LOAD) begin
      next_q  = d;
      out_bit = 1'b0;
    end
  end

endmodule : usr_step

// File: rtl/univ_shift_reg_n.sv
// Parametrised universal shift register with a start/busy/done batch engine.
// Optional macro PARITY_EN adds a registered parity output of q.
module univ_shift_reg_n
  import usr_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             enb,
  input  logic             dir,
  input  logic             s_in,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] q,
  output logic             s_out,
  output logic             busy,
  output logic             done
`ifdef PARITY_EN
  ,
  output logic             parity
`endif
);

  state_t           r_state, w_nx_state;
  logic [WIDTH-1:0] r_q, w_nx_q;
  logic             r_s_out, w_nx_s_out;
  logic             r_busy, w_nx_busy;
  logic             r_done, w_nx_done;
  logic [CNT_W-1:0] r_rem, w_nx_rem;
  logic [1:0]       r_mode, w_nx_mode;
  logic             r_dir, w_nx_dir;

  logic [1:0]       w_step_mode;
  logic             w_step_dir;
  logic [WIDTH-1:0] w_step_q;
  logic             w_step_out;

  // The batch engine uses the latched mode/dir; direct mode uses live inputs
  assign w_step_mode = (r_state == ST_RUN) ? r_mode : mode;
  assign w_step_dir  = (r_state == ST_RUN) ? r_dir  : dir;

  usr_step #(.WIDTH(WIDTH)) u_step (
    .q       (r_q),
    .mode    (w_step_mode),
    .dir     (w_step_dir),
    .s_in    (s_in),
    .d       (d),
    .next_q  (w_step_q),
    .out_bit (w_step_out)
  );

  // Next-state and next-register logic for direct and batch operation
  always_comb begin
    w_nx_state = r_state;
    w_nx_q     = r_q;
    w_nx_s_out = r_s_out;
    w_nx_busy  = r_busy;
    w_nx_done  = 1'b0;
    w_nx_rem   = r_rem;
    w_nx_mode  = r_mode;
    w_nx_dir   = r_dir;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_nx_mode = mode;
          w_nx_dir  = dir;
          if ((count == CNT_W'(0)) || (mode == MODE_LOAD)) begin
            if (mode == MODE_LOAD) begin
              w_nx_q = w_step_q;
            end
            w_nx_state = ST_DONE;
          end else begin
            w_nx_state = ST_RUN;
            w_nx_busy  = 1'b1;
            w_nx_rem   = count;
          end
        end else if (enb) begin
          w_nx_q = w_step_q;
          if (mode != MODE_LOAD) begin
            w_nx_s_out = w_step_out;
          end
        end
      end
      ST_RUN: begin
        if (enb) begin
          w_nx_q     = w_step_q;
          w_nx_s_out = w_step_out;
          w_nx_rem   = CNT_W'(r_rem - CNT_W'(1));
          if (r_rem == CNT_W'(1)) begin
            w_nx_state = ST_DONE;
            w_nx_busy  = 1'b0;
          end
        end
      end
      ST_DONE: begin
        // done is registered, so it appears in the cycle after DONE
        w_nx_done  = 1'b1;
        w_nx_state = ST_IDLE;
      end
      default: begin
        w_nx_state = ST_IDLE;
        w_nx_busy  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_s_out <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rem   <= '0;
      r_mode  <= MODE_SHIFT;
      r_dir   <= DIR_LEFT;
    end else begin
      r_state <= w_nx_state;
      r_q     <= w_nx_q;
      r_s_out <= w_nx_s_out;
      r_busy  <= w_nx_busy;
      r_done  <= w_nx_done;
      r_rem   <= w_nx_rem;
      r_mode  <= w_nx_mode;
      r_dir   <= w_nx_dir;
    end
  end

  assign q     = r_q;
  assign s_out = r_s_out;
  assign busy  = r_busy;
  assign done  = r_done;

`ifdef PARITY_EN
  logic r_parity;

  // Parity of the value q takes on the same edge
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      r_parity <= 1'b0;
    end else begin
      r_parity <= ^w_nx_q;
    end
  end

  assign parity = r_parity;
`endif

endmodule : univ_shift_reg_n

// File: tb/tb_univ_shift_reg_n.sv
// Directed scoreboard bench for univ_shift_reg_n (8-bit and 32-bit instances).
module tb_univ_shift_reg_n;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic        clk = 1'b0;
  logic        reset_L, enb, dir, s_in, start;
  logic [1:0]  mode;
  logic [5:0]  count;
  logic [7:0]  d8;
  logic [31:0] d32;
  logic [7:0]  q8;
  logic [31:0] q32;
  logic        s_out8, busy8, done8;
  logic        s_out32, busy32, done32;
`ifdef PARITY_EN
  logic        parity8, parity32;
`endif

  always #5 clk = ~clk;

  univ_shift_reg_n #(.WIDTH(8), .CNT_W(6)) dut8 (
    .clk(clk), .reset_L(reset_L), .enb(enb), .dir(dir), .s_in(s_in),
    .mode(mode), .d(d8), .start(start), .count(count),
    .q(q8), .s_out(s_out8), .busy(busy8), .done(done8)
`ifdef PARITY_EN
    , .parity(parity8)
`endif
  );

  univ_shift_reg_n #(.WIDTH(32), .CNT_W(6)) dut32 (
    .clk(clk), .reset_L(reset_L), .enb(enb), .dir(dir), .s_in(s_in),
    .mode(mode), .d(d32), .start(start), .count(count),
    .q(q32), .s_out(s_out32), .busy(busy32), .done(done32)
`ifdef PARITY_EN
    , .parity(parity32)
`endif
  );

  task automatic push(input string t, input logic [31:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_chk(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val)
      else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam int unsigned NSTALL = 5;

  initial begin
    logic [31:0] m;
    logic [31:0] orig;
    logic        stall_enb [NSTALL];
    logic        stall_sin [NSTALL];
    stall_enb = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    stall_sin = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset with enb=1 and d all ones
    reset_L = 1'b0; enb = 1'b1; dir = 1'b0; s_in = 1'b0; start = 1'b0;
    mode = 2'b10; count = '0; d8 = 8'hFF; d32 = 32'hFFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      push("rst_q8", 32'h0); push("rst_sout8", 32'h0);
      push("rst_busy8", 32'h0); push("rst_done8", 32'h0); push("rst_q32", 32'h0);
      tick();
      pop_chk(32'(q8)); pop_chk(32'(s_out8)); pop_chk(32'(busy8));
      pop_chk(32'(done8)); pop_chk(q32);
    end
`ifdef PARITY_EN
    push("rst_parity8", 32'h0); pop_chk(32'(parity8));
`endif
    reset_L = 1'b1; enb = 1'b0;
    push("post_rst_hold", 32'h0); tick(); pop_chk(32'(q8));

    // Direct operations on the 8-bit instance
    enb = 1'b1; mode = 2'b10; d8 = 8'hA5;
    push("load_A5", 32'hA5); tick(); pop_chk(32'(q8));
    mode = 2'b01; dir = 1'b1;
    push("rotr_q", 32'hD2); push("rotr_sout", 32'h1);
    tick(); pop_chk(32'(q8)); pop_chk(32'(s_out8));
    mode = 2'b11; dir = 1'b1;
    push("asr_q", 32'hE9); push("asr_sout", 32'h0);
    tick(); pop_chk(32'(q8)); pop_chk(32'(s_out8));
    mode = 2'b00; dir = 1'b0; s_in = 1'b1;
    push("lsl_q", 32'hD3); push("lsl_sout", 32'h1);
    tick(); pop_chk(32'(q8)); pop_chk(32'(s_out8));
`ifdef PARITY_EN
    mode = 2'b10; d8 = 8'h07;
    push("par_load07", 32'h1); tick(); pop_chk(32'(parity8));
    mode = 2'b00; dir = 1'b0; s_in = 1'b0;
    push("par_q0E", 32'h0E); push("par_0E", 32'h1);
    tick(); pop_chk(32'(q8)); pop_chk(32'(parity8));
    mode = 2'b10; d8 = 8'h03;
    push("par_load03", 32'h0); tick(); pop_chk(32'(parity8));
`endif

    // Batch rotate left by 4 on the 32-bit instance
    mode = 2'b10; d32 = 32'h8000_0001; enb = 1'b1;
    push("b_load", 32'h8000_0001); tick(); pop_chk(q32);
    mode = 2'b01; dir = 1'b0; count = 6'd4; start = 1'b1;
    push("b_start_q", 32'h8000_0001); push("b_start_busy", 32'h1); push("b_start_done", 32'h0);
    tick(); pop_chk(q32); pop_chk(32'(busy32)); pop_chk(32'(done32));
    start = 1'b0;
    m = 32'h8000_0001;
    for (int i = 1; i <= 4; i++) begin
      m = {m[30:0], m[31]};
      push("b_rot_q", m); push("b_rot_busy", (i < 4) ? 32'h1 : 32'h0);
      push("b_rot_done", 32'h0);
      tick(); pop_chk(q32); pop_chk(32'(busy32)); pop_chk(32'(done32));
    end
    enb = 1'b0;
    push("b_done_edge5", 32'h1); push("b_q_final", 32'h0000_0018);
    tick(); pop_chk(32'(done32)); pop_chk(q32);
    push("b_done_drop", 32'h0); tick(); pop_chk(32'(done32));

    // Batch logical right by 3 with a two-cycle stall and toggled mode/dir
    mode = 2'b10; d32 = 32'h0000_00F0; enb = 1'b1;
    push("s_load", 32'hF0); tick(); pop_chk(q32);
    mode = 2'b00; dir = 1'b1; count = 6'd3; start = 1'b1; s_in = 1'b0;
    push("s_start_busy", 32'h1); tick(); pop_chk(32'(busy32));
    start = 1'b0; mode = 2'b01; dir = 1'b0; d32 = 32'hDEAD_BEEF; count = 6'd7;
    m = 32'h0000_00F0;
    for (int i = 0; i < int'(NSTALL); i++) begin
      enb = stall_enb[i]; s_in = stall_sin[i];
      if (stall_enb[i]) m = {stall_sin[i], m[31:1]};
      push("s_q", m); push("s_busy", (i < int'(NSTALL) - 1) ? 32'h1 : 32'h0);
      push("s_done", 32'h0);
      tick(); pop_chk(q32); pop_chk(32'(busy32)); pop_chk(32'(done32));
    end
    enb = 1'b0; s_in = 1'b0;
    push("s_done_late", 32'h1); push("s_q_final", 32'h8000_001E);
    tick(); pop_chk(32'(done32)); pop_chk(q32);

    // count == 0: no change, done next cycle
    orig = q32;
    mode = 2'b00; dir = 1'b0; count = 6'd0; start = 1'b1; enb = 1'b1;
    push("z_q", orig); push("z_busy", 32'h0); push("z_done0", 32'h0);
    tick(); pop_chk(q32); pop_chk(32'(busy32)); pop_chk(32'(done32));
    start = 1'b0; enb = 1'b0;
    push("z_done1", 32'h1); push("z_q_hold", orig);
    tick(); pop_chk(32'(done32)); pop_chk(q32);
    push("z_done2", 32'h0); tick(); pop_chk(32'(done32));

    // Rotate right by WIDTH restores the value
    mode = 2'b01; dir = 1'b1; count = 6'd32; start = 1'b1; enb = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 31; i++) tick();
    push("w_busy_last", 32'h1); pop_chk(32'(busy32));
    tick();
    enb = 1'b0;
    push("w_q_restored", orig); push("w_busy_end", 32'h0);
    pop_chk(q32); pop_chk(32'(busy32));
    push("w_done", 32'h1); tick(); pop_chk(32'(done32));

    // Reset in mid-RUN aborts with no done pulse
    mode = 2'b00; dir = 1'b0; count = 6'd10; start = 1'b1; enb = 1'b1; s_in = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    push("r_busy_mid", 32'h1); pop_chk(32'(busy32));
    reset_L = 1'b0;
    push("r_q", 32'h0); push("r_busy", 32'h0);
    tick(); pop_chk(q32); pop_chk(32'(busy32));
    reset_L = 1'b1; enb = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push("r_no_done", 32'h0); tick(); pop_chk(32'(done32));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_univ_shift_reg_n

// File: doc/univ_shift_reg_n.md
Name: univ_shift_reg_n

Overview:
Parametrised universal shift register, successor to the fixed 32-bit register. Adds a width parameter, an arithmetic-shift mode, and a multi-cycle batch shift engine with a start/busy/done handshake. The engine shifts or rotates the register by a programmed count without the host pulsing the enable each step. Used as a serial/parallel conversion and bit-alignment element in the datapath labs; chains serially via s_in/s_out.

Parameters:
WIDTH, 32, register width in bits (>=2)
CNT_W, 6, width of the count input; must satisfy 2**CNT_W > WIDTH

Ports:
clk  in  1  rising-edge clock
reset_L  in  1  synchronous active-low reset, sampled on rising clk edge
enb  in  1  step enable; in direct mode a 1 performs one operation; in RUN a 0 stalls the engine
dir  in  1  0 = shift left (toward MSB), 1 = shift right (toward LSB)
s_in  in  1  serial input bit
mode  in  2  00 logical shift, 01 rotate, 10 parallel load, 11 arithmetic shift
d  in  WIDTH  parallel load data
start  in  1  request a batch operation
count  in  CNT_W  batch step count
q  out  WIDTH  register contents
s_out  out  1  last bit shifted out (registered)
busy  out  1  engine is running a batch
done  out  1  one-cycle pulse when a batch completes

Behaviour:
- Reset (reset_L=0 at an edge): q=0, s_out=0, busy=0, done=0, FSM to IDLE. Reset overrides everything, including an in-progress batch, which is aborted.
- One step, selected by mode and dir:
  - 00 logical: left q<={q[W-2:0],s_in}, s_out<=q[W-1]; right q<={s_in,q[W-1:1]}, s_out<=q[0].
  - 01 rotate: the bit leaving the register re-enters at the other end; s_out gets the leaving bit; s_in is ignored.
  - 10 load: q<=d; s_out is unchanged.
  - 11 arithmetic: right q<={q[W-1],q[W-1:1]}; left behaves as logical left with a 0 fill; s_out gets the leaving bit.
- FSM states: IDLE, RUN, DONE.
- IDLE with start=0: if enb=1, perform one step per cycle. If enb=0, hold.
- IDLE with start=1 (start has priority over direct mode in that cycle):
  - Latch mode, dir and count.
  - count==0 or mode==10: perform a single load in that same cycle if mode==10, otherwise no change. Go to DONE.
  - Otherwise: no change to q this cycle. Go to RUN, busy<=1, remaining<=count.
- RUN:
  - Each cycle with enb=1: perform one step using the latched mode and dir, and decrement remaining. When the step taken has remaining==1, go to DONE and busy<=0.
  - enb=0 stalls: q, s_out and remaining hold.
  - mode, dir, start, count and d inputs are ignored while busy=1.
  - s_in is still sampled live during RUN for logical shifts.
- DONE: done=1 for exactly one cycle, then return to IDLE. start is ignored in DONE. Direct operation does not occur in DONE.
- A batch of N steps with no stalls: busy is high N cycles after the start edge; done rises on edge N+1 (the start edge counts as edge 0).
- count > WIDTH is legal and performs count full steps; for example, rotate by WIDTH restores the original value.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
PARITY_EN
- Defined: adds output port parity (1 bit) = registered XOR of the next value of q, updated on the same edge as q; it resets to 0.
- Not defined: the parity port and its logic are absent; the port list is exactly as above.

Decomposition:
- Shared package usr_pkg holds:
  - mode encodings MODE_SHIFT=2'b00, MODE_ROT=2'b01, MODE_LOAD=2'b10, MODE_ARITH=2'b11;
  - DIR_LEFT=0 and DIR_RIGHT=1;
  - FSM state encodings ST_IDLE, ST_RUN, ST_DONE.
- One combinational sub-module, usr_step: inputs q, mode, dir, s_in, d; outputs next_q and out_bit. It is instantiated once and shared by direct and batch paths.
- The top module holds the FSM, the remaining counter and the registers.

Test Plan:
- Reset: drive reset_L=0 for 2 cycles with enb=1 and d=all ones -> q=0, s_out=0, busy=0, done=0; release -> q stays 0 until the first enb.
- Direct ops, WIDTH=8: load 8'hA5; rotate right once -> 8'hD2, s_out=1; arithmetic right once -> 8'hE9, s_out=0; logical left with s_in=1 -> 8'hD3, s_out=1.
- Batch, WIDTH=32: q=32'h8000_0001, mode=01, dir=0, start with count=4 -> busy for 4 cycles, q=32'h0000_0018, single done pulse on edge 5.
- Stall and ignore: during a count=3 logical right batch, drop enb for 2 cycles and toggle mode/dir -> q frozen during the stall, latched mode/dir used, done arrives 2 cycles later than with no stall.
- Edge cases: count=0 start -> no q change, done pulse the next cycle. Rotate with count=WIDTH -> q unchanged. Reset asserted in mid-RUN -> q=0, busy=0, and no done pulse.
- PARITY_EN build: load 8'h07 -> parity=1; logical left with s_in=0 -> 8'h0E, parity=1; load 8'h03 -> parity=0.
